// File: rtl/light_conflict_monitor_pkg.sv
// Shared light encodings, monitor state and fault_code bit positions.
// The upstream controller uses the same constants, so both sides agree on the encoding.
package light_conflict_monitor_pkg;

  localparam logic [2:0] OFF    = 3'b000;
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] RED    = 3'b100;

  localparam int FC_CONFLICT = 0;
  localparam int FC_INVALID  = 1;
  localparam int FC_WATCHDOG = 2;

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_FLASH   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  // Lamp vectors are packed as {M1, M2, MT, S}.
  localparam logic [11:0] ALL_RED = {RED, RED, RED, RED};

  function automatic logic [11:0] flash_pattern(input logic on_phase);
    return on_phase ? {YELLOW, YELLOW, YELLOW, RED} : {OFF, OFF, OFF, OFF};
  endfunction

  function automatic logic is_valid_light(input logic [2:0] light);
    return (light == GREEN) || (light == YELLOW) || (light == RED);
  endfunction

endpackage

// File: rtl/light_conflict_monitor_check.sv
// Combinational invalid-encoding and green/green conflict detection.
// M1+M2 and M1+MT greens are legal; S against any main road and MT against M2 are not.
module light_conflict_check
  import light_conflict_monitor_pkg::*;
(
  input  logic [2:0] m1,
  input  logic [2:0] m2,
  input  logic [2:0] mt,
  input  logic [2:0] s,
  output logic [1:0] fault_bits
);

  logic invalid;
  logic conflict;

  always_comb begin
    invalid  = !(is_valid_light(m1) && is_valid_light(m2) &&
                 is_valid_light(mt) && is_valid_light(s));
    conflict = ((s == GREEN) && ((m1 == GREEN) || (m2 == GREEN) || (mt == GREEN))) ||
               ((mt == GREEN) && (m2 == GREEN));
  end

  always_comb begin
    fault_bits              = 2'b00;
    fault_bits[FC_CONFLICT] = conflict;
    fault_bits[FC_INVALID]  = invalid;
  end

endmodule

// File: rtl/light_conflict_monitor.sv
// Safety monitor between a traffic controller and its lamps: passes healthy
// requests through with one cycle of latency, flashes on any fault, and needs a clean recovery window.
module light_conflict_monitor
  import light_conflict_monitor_pkg::*;
#(
  parameter int FLASH_HALF     = 4,
  parameter int WDOG_CYCLES    = 32,
  parameter int RECOVER_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] in_M1,
  input  logic [2:0] in_M2,
  input  logic [2:0] in_MT,
  input  logic [2:0] in_S,
  input  logic       clr_fault,
  output logic [2:0] lamp_M1,
  output logic [2:0] lamp_M2,
  output logic [2:0] lamp_MT,
  output logic [2:0] lamp_S,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int WDOG_W  = $clog2(WDOG_CYCLES + 1);
  localparam int REC_W   = $clog2(RECOVER_CYCLES + 1);
  localparam int FLASH_W = $clog2(FLASH_HALF + 1);
  localparam logic [WDOG_W-1:0]  WDOG_LAST  = WDOG_W'(WDOG_CYCLES - 1);
  localparam logic [REC_W-1:0]   REC_LAST   = REC_W'(RECOVER_CYCLES - 1);
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_HALF - 1);

  state_t             state;
  logic [11:0]        cur_in;
  logic [11:0]        prev_in;
  logic [11:0]        lamp_reg;
  logic [WDOG_W-1:0]  wdog_count;
  logic [WDOG_W-1:0]  wdog_next;
  logic [REC_W-1:0]   rec_count;
  logic [FLASH_W-1:0] flash_count;
  logic               flash_on;
  logic               wdog_expired;
  logic [1:0]         check_bits;
  logic [2:0]         faults;
  logic               healthy;

  assign cur_in = {in_M1, in_M2, in_MT, in_S};

  light_conflict_check u_check (
    .m1         (in_M1),
    .m2         (in_M2),
    .mt         (in_MT),
    .s          (in_S),
    .fault_bits (check_bits)
  );

  // The watchdog sees this cycle's repeat immediately, so a stuck input is flagged
  // on the same cycle the count reaches its limit; the count saturates there.
  always_comb begin
    wdog_next = '0;
    if (cur_in == prev_in) begin
      wdog_next = (wdog_count == WDOG_LAST) ? WDOG_LAST : wdog_count + 1'b1;
    end
    wdog_expired = (wdog_next == WDOG_LAST);
  end

  always_comb begin
    faults              = 3'b000;
    faults[FC_CONFLICT] = check_bits[FC_CONFLICT];
    faults[FC_INVALID]  = check_bits[FC_INVALID];
    faults[FC_WATCHDOG] = wdog_expired;
    healthy             = (faults == 3'b000);
  end

  // An unhealthy input loads the flash pattern instead of the request, so a bad
  // combination never reaches a lamp, even for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RECOVER;
      lamp_reg    <= ALL_RED;
      fault       <= 1'b0;
      fault_code  <= 3'b000;
      prev_in     <= '0;
      wdog_count  <= '0;
      rec_count   <= '0;
      flash_count <= '0;
      flash_on    <= 1'b1;
    end else begin
      prev_in    <= cur_in;
      wdog_count <= wdog_next;
      case (state)
        ST_NORMAL: begin
          if (healthy) begin
            lamp_reg <= cur_in;
          end else begin
            state       <= ST_FLASH;
            fault       <= 1'b1;
            fault_code  <= faults;
            flash_count <= '0;
            flash_on    <= 1'b1;
            lamp_reg    <= flash_pattern(1'b1);
          end
        end
        ST_FLASH: begin
          fault_code <= fault_code | faults;
          if (flash_count == FLASH_LAST) begin
            flash_count <= '0;
            flash_on    <= ~flash_on;
            lamp_reg    <= flash_pattern(~flash_on);
          end else begin
            flash_count <= flash_count + 1'b1;
          end
          if (clr_fault && healthy) begin
            state       <= ST_RECOVER;
            lamp_reg    <= ALL_RED;
            fault       <= 1'b0;
            fault_code  <= 3'b000;
            wdog_count  <= '0;
            rec_count   <= '0;
            flash_count <= '0;
            flash_on    <= 1'b1;
          end
        end
        ST_RECOVER: begin
          if (!healthy) begin
            state       <= ST_FLASH;
            fault       <= 1'b1;
            fault_code  <= faults;
            rec_count   <= '0;
            flash_count <= '0;
            flash_on    <= 1'b1;
            lamp_reg    <= flash_pattern(1'b1);
          end else if (rec_count == REC_LAST) begin
            state     <= ST_NORMAL;
            rec_count <= '0;
            lamp_reg  <= cur_in;
          end else begin
            rec_count <= rec_count + 1'b1;
          end
        end
        default: begin
          state     <= ST_RECOVER;
          lamp_reg  <= ALL_RED;
          fault     <= 1'b0;
          rec_count <= '0;
        end
      endcase
    end
  end

  assign lamp_M1 = lamp_reg[11:9];
  assign lamp_M2 = lamp_reg[8:6];
  assign lamp_MT = lamp_reg[5:3];
  assign lamp_S  = lamp_reg[2:0];

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Scoreboard bench for light_conflict_monitor: stimulus queues hand-computed
// expectations per cycle, and a monitor pops and compares them after each clock edge.
module tb_light_conflict_monitor;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;
  localparam logic [11:0] RED4    = {R, R, R, R};
  localparam logic [11:0] FL_ON   = {Y, Y, Y, R};
  localparam logic [11:0] FL_OFF  = 12'h000;
  localparam logic [11:0] VA      = {G, G, R, R};
  localparam logic [11:0] VB      = {G, Y, R, R};
  localparam logic [11:0] VC      = {G, R, G, R};
  localparam logic [11:0] VD      = {Y, R, Y, R};
  localparam logic [11:0] VE      = {R, R, R, G};
  localparam logic [11:0] VX      = {R, R, R, Y};
  localparam logic [11:0] CONF_S  = {G, R, R, G};
  localparam logic [11:0] CONF_MT = {R, G, G, R};
  localparam logic [11:0] INV_MT  = {R, R, 3'b011, R};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] in_M1, in_M2, in_MT, in_S;
  logic       clr_fault = 1'b0;
  logic [2:0] lamp_M1, lamp_M2, lamp_MT, lamp_S;
  logic       fault;
  logic [2:0] fault_code;

  logic [11:0] hv [4];
  logic [15:0] expQ[$];
  string       nameQ[$];
  int          compared = 0;
  int          mismatched = 0;

  light_conflict_monitor #(.FLASH_HALF(4), .WDOG_CYCLES(32), .RECOVER_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_M1      (in_M1),
    .in_M2      (in_M2),
    .in_MT      (in_MT),
    .in_S       (in_S),
    .clr_fault  (clr_fault),
    .lamp_M1    (lamp_M1),
    .lamp_M2    (lamp_M2),
    .lamp_MT    (lamp_MT),
    .lamp_S     (lamp_S),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] actualVec();
    return {lamp_M1, lamp_M2, lamp_MT, lamp_S, fault, fault_code};
  endfunction

  task automatic reportCompare(input string name, input logic [15:0] act, input logic [15:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got lamps=%h fault=%b code=%b, expected lamps=%h fault=%b code=%b",
               name, act[15:4], act[3], act[2:0], expv[15:4], expv[3], expv[2:0]);
    end
  endtask

  // Drives one cycle of inputs at the falling edge and queues what the lamps must show after the next rising edge.
  task automatic applyStimulus(input logic [11:0] vec, input logic clr, input logic [11:0] expLamps,
                               input logic expFault, input logic [2:0] expCode, input string name);
    @(negedge clk);
    rst = 1'b0;
    {in_M1, in_M2, in_MT, in_S} = vec;
    clr_fault = clr;
    expQ.push_back({expLamps, expFault, expCode});
    nameQ.push_back(name);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] expv);
    reportCompare(name, actualVec(), expv);
  endtask

  task automatic recoverThenNormal(input string name);
    for (int r = 1; r <= 16; r++) begin
      if (r < 16) applyStimulus(hv[r % 4], 1'b0, RED4, 1'b0, 3'b000, {name, "_hold"});
      else        applyStimulus(hv[r % 4], 1'b0, hv[r % 4], 1'b0, 3'b000, {name, "_exit"});
    end
  endtask

  task automatic flashRun(input int first, input int last, input logic [2:0] code, input string name);
    for (int f = first; f <= last; f++) begin
      applyStimulus(hv[f % 4], 1'b0, (((f / 4) % 2) == 0) ? FL_ON : FL_OFF, 1'b1, code, name);
    end
  endtask

  initial begin : monitor
    logic [15:0] e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() != 0) begin
        e  = expQ.pop_front();
        nm = nameQ.pop_front();
        reportCompare(nm, actualVec(), e);
      end
    end
  end

  initial begin : timeout
    #100000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int n;
    hv[0] = VA; hv[1] = VB; hv[2] = VC; hv[3] = VD;
    {in_M1, in_M2, in_MT, in_S} = VA;
    #1 rst = 1'b1;
    #2 checkOutput("reset_state", {RED4, 1'b0, 3'b000});

    // Controller sequence after reset: 16 red cycles, then one-cycle-lag tracking.
    n = 0;
    for (int i = 0; i < 8; i++) begin n++; applyStimulus(VA, 1'b0, (n < 16) ? RED4 : VA, 1'b0, 3'b000, "track"); end
    for (int i = 0; i < 3; i++) begin n++; applyStimulus(VB, 1'b0, (n < 16) ? RED4 : VB, 1'b0, 3'b000, "track"); end
    for (int i = 0; i < 6; i++) begin n++; applyStimulus(VC, 1'b0, (n < 16) ? RED4 : VC, 1'b0, 3'b000, "track"); end
    for (int i = 0; i < 4; i++) begin n++; applyStimulus(VD, 1'b0, (n < 16) ? RED4 : VD, 1'b0, 3'b000, "track"); end
    for (int i = 0; i < 4; i++) begin n++; applyStimulus(VE, 1'b0, (n < 16) ? RED4 : VE, 1'b0, 3'b000, "track"); end
    for (int i = 0; i < 3; i++) begin n++; applyStimulus(VA, 1'b0, (n < 16) ? RED4 : VA, 1'b0, 3'b000, "track"); end

    // S green with M1 green: straight to flash, never shown on lamps.
    applyStimulus(CONF_S, 1'b0, FL_ON, 1'b1, 3'b001, "conflict_entry");
    flashRun(1, 8, 3'b001, "conflict_flash");
    applyStimulus(CONF_S, 1'b1, FL_ON, 1'b1, 3'b001, "clr_ignored");
    applyStimulus(VB, 1'b1, RED4, 1'b0, 3'b000, "clr_accept");
    for (int r = 1; r <= 9; r++) applyStimulus(hv[(r + 2) % 4], 1'b0, RED4, 1'b0, 3'b000, "recover_early");
    applyStimulus(CONF_MT, 1'b0, FL_ON, 1'b1, 3'b001, "recover_conflict");
    applyStimulus(VB, 1'b0, FL_ON, 1'b1, 3'b001, "reflash");
    applyStimulus(VC, 1'b0, FL_ON, 1'b1, 3'b001, "reflash");
    applyStimulus(VD, 1'b1, RED4, 1'b0, 3'b000, "clr_accept2");
    recoverThenNormal("recover1");

    // Invalid encoding on MT, flash cadence, and a later conflict OR-ing into the code.
    applyStimulus(INV_MT, 1'b0, FL_ON, 1'b1, 3'b010, "invalid_entry");
    flashRun(1, 12, 3'b010, "invalid_flash");
    applyStimulus(CONF_S, 1'b0, FL_OFF, 1'b1, 3'b011, "code_or");
    applyStimulus(VC, 1'b0, FL_OFF, 1'b1, 3'b011, "code_sticky");
    applyStimulus(VD, 1'b1, RED4, 1'b0, 3'b000, "clr_accept3");
    recoverThenNormal("recover2");

    // Stuck controller: the 32nd identical cycle trips the watchdog.
    for (int k = 1; k <= 31; k++) applyStimulus(VX, 1'b0, VX, 1'b0, 3'b000, "wdog_hold");
    applyStimulus(VX, 1'b0, FL_ON, 1'b1, 3'b100, "wdog_entry");
    applyStimulus(VX, 1'b0, FL_ON, 1'b1, 3'b100, "wdog_sticky");

    // Asynchronous reset between edges while flashing.
    @(posedge clk);
    #3 rst = 1'b1;
    #1 checkOutput("async_reset", {RED4, 1'b0, 3'b000});
    recoverThenNormal("recover3");

    repeat (3) @(posedge clk);
    #2;
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/light_conflict_monitor.md
LIGHT_CONFLICT_MONITOR -- requirements
Module: light_conflict_monitor

Interface
REQ-001 Parameter FLASH_HALF, 4, cycles per half-period of fault flashing (>=1).
REQ-002 Parameter WDOG_CYCLES, 32, consecutive cycles of unchanged input that constitute a stuck-controller fault (>=2).
REQ-003 Parameter RECOVER_CYCLES, 16, consecutive healthy cycles required in RECOVER before NORMAL (>=1).
REQ-004 clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-005 in_M1, in_M2, in_MT, in_S  in  3 each  controller light requests; 3'b001 green, 3'b010 yellow, 3'b100 red.
REQ-006 clr_fault  in  1  operator fault-clear pulse.
REQ-007 lamp_M1, lamp_M2, lamp_MT, lamp_S  out  3 each  registered lamp drive, same encoding.
REQ-008 fault  out  1  high while in FLASH.
REQ-009 fault_code  out  3  bit0 conflict, bit1 invalid encoding, bit2 watchdog; sticky while in FLASH.

Function
REQ-010 Invalid: any input not exactly one of 001/010/100.
REQ-011 Conflict: green on S together with green on any of M1/M2/MT, or green on MT together with green on M2; M1+M2 and M1+MT greens are legal.
REQ-012 Watchdog: counter increments each cycle the 12-bit concatenated input equals its previous-cycle value, clears on any change and on RECOVER entry; expired when count reaches WDOG_CYCLES-1.
REQ-013 Healthy: no invalid, no conflict, watchdog not expired, all evaluated combinationally on current inputs.
REQ-014 States: NORMAL, FLASH, RECOVER (3-state FSM).
REQ-015 NORMAL: lamps load inputs next edge (1-cycle latency); if not healthy, go to FLASH and lamps load flash pattern instead, so an unhealthy combination never reaches any lamp.
REQ-016 FLASH: on-phase M1/M2/MT = 010, S = 100; off-phase all 000; on-phase first, phase toggles every FLASH_HALF cycles.
REQ-017 FLASH entry captures fault_code from the detecting cycle; further faults OR into fault_code; fault_code clears on leaving FLASH.
REQ-018 FLASH -> RECOVER only when clr_fault=1 and inputs healthy in the same cycle; clr_fault with unhealthy inputs is ignored.
REQ-019 RECOVER: all lamps 100; healthy-cycle counter increments; reaching RECOVER_CYCLES -> NORMAL; any unhealthy cycle -> FLASH (counter cleared).
REQ-020 clr_fault in NORMAL or RECOVER has no effect.
REQ-021 Counters saturate/clear per state; no wrap-around permitted.

Reset
REQ-022 rst asserts asynchronously: state RECOVER, all lamps 100, fault 0, fault_code 000, all counters 0.
REQ-023 rst mid-FLASH drops flashing immediately to all-red; first NORMAL cycle no earlier than RECOVER_CYCLES healthy cycles after release.

Structure
REQ-024 Shared package holds light-encoding constants (GREEN/YELLOW/RED/OFF), state enum, and fault_code bit indices; the upstream controller uses the same constants.
REQ-025 One sub-module, light_conflict_check: purely combinational invalid/conflict detection producing the 2 fault bits; FSM, watchdog and flash counters stay in the top.

Verification
REQ-026 Reset, then drive controller sequence (M1/M2 green 8, M2 yellow 3, M1+MT green 6, ...) -> all-red 16 cycles, then lamps track inputs with 1-cycle lag, fault 0.
REQ-027 In NORMAL force in_S=001 with in_M1=001 for one cycle -> next edge fault=1, fault_code=001, lamps 010/010/010/100; green-green never visible on lamps.
REQ-028 In NORMAL drive in_MT=011 -> fault_code=010; FLASH_HALF=4 gives 4 cycles on, 4 cycles off, repeating.
REQ-029 Hold inputs constant 32 cycles -> FLASH with fault_code=100 on cycle 32.
REQ-030 In FLASH pulse clr_fault with conflict present -> stays FLASH; pulse with healthy inputs -> all-red, NORMAL after 16 healthy cycles; inject conflict at RECOVER cycle 10 -> back to FLASH.
REQ-031 Assert rst asynchronously mid-FLASH (between edges) -> lamps 100 immediately, fault 0, fault_code 000.
